// File: rtl/prt_dptx_mst_sched.sv
// DisplayPort TX MST time-slot scheduler.
// Decodes a 64-slot MTP into per-symbol stream codes from an active
// allocation and runs the four-MTP ACT handshake that swaps in a
// shadow allocation at an MTP boundary.
module prt_dptx_mst_sched #(
  parameter int P_SPL   = 2,
  parameter int P_SLOTS = 64
) (
  input  logic               CLK_IN,
  input  logic               RST_IN,
  input  logic               EN_IN,
  input  logic               CFG_WR_IN,
  input  logic               CFG_SEL_IN,
  input  logic [5:0]         CFG_START_IN,
  input  logic [5:0]         CFG_LEN_IN,
  input  logic               ACT_IN,
  output logic [2*P_SPL-1:0] SLOT_SEL_OUT,
  output logic               MTP_SOM_OUT,
  output logic               ACT_SEQ_OUT,
  output logic               ACT_BUSY_OUT,
  output logic               ACT_DONE_OUT
);

  localparam int CW = $clog2(P_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SEND, S_SWAP} state_t;

  state_t             state_q;
  logic [1:0]         mtp_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0][5:0]    shd_start_q, shd_len_q;
  logic [1:0][5:0]    act_start_q, act_len_q;
  logic [1:0][5:0]    eff_start, eff_len;
  logic [2*P_SPL-1:0] sel_d, sel_q;
  logic               som_d, som_q;
  logic               act_seq_q, done_q;
  logic               boundary;
  logic               swap_now;

  // True when slot s falls in [start, start+len); start 0 behaves as 1,
  // and the 7-bit end lets ranges run past 63 without wrapping to slot 0.
  function automatic logic in_range(input logic [5:0] s,
                                    input logic [5:0] st,
                                    input logic [5:0] ln);
    logic [6:0] lo;
    logic [6:0] hi;
    lo = (st == 6'd0) ? 7'd1 : {1'b0, st};
    hi = lo + {1'b0, ln};
    return ({1'b0, s} >= lo) && ({1'b0, s} < hi);
  endfunction

  // Slot code: 3 = MTPH on slot 0, then stream 0 wins over stream 1.
  function automatic logic [1:0] slot_code(input logic [5:0] s,
                                           input logic [5:0] st0,
                                           input logic [5:0] ln0,
                                           input logic [5:0] st1,
                                           input logic [5:0] ln1);
    if (s == 6'd0)                 return 2'd3;
    else if (in_range(s, st0, ln0)) return 2'd1;
    else if (in_range(s, st1, ln1)) return 2'd2;
    else                            return 2'd0;
  endfunction

  assign boundary = EN_IN && (cnt_q == '0);
  assign swap_now = (state_q == S_SWAP) && boundary;

  // The MTP in which the swap happens is decoded with the incoming
  // allocation, so slot 1 onwards of that MTP already uses it.
  assign eff_start = swap_now ? shd_start_q : act_start_q;
  assign eff_len   = swap_now ? shd_len_q   : act_len_q;

  // Slot counter: steps P_SPL slots per clock, parked at 0 when disabled.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || !EN_IN) cnt_q <= '0;
    else                  cnt_q <= cnt_q + CW'(P_SPL);
  end

  // Shadow allocation register, written directly by the config port.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      shd_start_q <= {6'd1, 6'd1};
      shd_len_q   <= '0;
    end else if (CFG_WR_IN) begin
      shd_start_q[CFG_SEL_IN] <= CFG_START_IN;
      shd_len_q[CFG_SEL_IN]   <= CFG_LEN_IN;
    end
  end

  // Per-symbol decode of the slots covered this cycle.
  always_comb begin
    sel_d = '0;
    som_d = boundary;
    if (EN_IN) begin
      for (int j = 0; j < P_SPL; j++) begin
        sel_d[2*j +: 2] = slot_code(6'(cnt_q + CW'(j)),
                                    eff_start[0], eff_len[0],
                                    eff_start[1], eff_len[1]);
      end
    end
  end

  // Output register stage for the slot map and start-of-MTP flag.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      sel_q <= '0;
      som_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      som_q <= som_d;
    end
  end

  // ACT FSM: arm on ACT_IN, flag ACT in four consecutive MTPHs, then
  // copy shadow to active at the following MTP boundary.
  // mtp_q counts ACT MTPHs sent after the first one.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q     <= S_IDLE;
      mtp_q       <= '0;
      act_seq_q   <= 1'b0;
      done_q      <= 1'b0;
      act_start_q <= {6'd1, 6'd1};
      act_len_q   <= '0;
    end else begin
      act_seq_q <= 1'b0;
      done_q    <= 1'b0;
      if (EN_IN) begin
        case (state_q)
          S_IDLE: if (ACT_IN) state_q <= S_ARM;
          S_ARM: if (cnt_q == '0) begin
            state_q   <= S_SEND;
            mtp_q     <= '0;
            act_seq_q <= 1'b1;
          end
          S_SEND: if (cnt_q == '0) begin
            act_seq_q <= 1'b1;
            if (mtp_q == 2'd2) state_q <= S_SWAP;
            else               mtp_q   <= mtp_q + 2'd1;
          end
          S_SWAP: if (cnt_q == '0) begin
            act_start_q <= shd_start_q;
            act_len_q   <= shd_len_q;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign SLOT_SEL_OUT = sel_q;
  assign MTP_SOM_OUT  = som_q;
  assign ACT_SEQ_OUT  = act_seq_q;
  assign ACT_DONE_OUT = done_q;
  assign ACT_BUSY_OUT = (state_q != S_IDLE);

endmodule

// File: tb/tb_prt_dptx_mst_sched.sv
// Directed bench for prt_dptx_mst_sched with P_SPL=2 (32 cycles per MTP).
module tb_prt_dptx_mst_sched;

  logic       clk = 1'b0;
  logic       rst, en, cfg_wr, cfg_sel, act;
  logic [5:0] cfg_start, cfg_len;
  logic [3:0] sel;
  logic       som, act_seq, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [1:0] exp_map [64];
  logic       wr_sel_v;
  logic [5:0] wr_start_v, wr_len_v;

  always #5 clk = ~clk;

  prt_dptx_mst_sched #(.P_SPL(2), .P_SLOTS(64)) dut (
    .CLK_IN(clk), .RST_IN(rst), .EN_IN(en), .CFG_WR_IN(cfg_wr),
    .CFG_SEL_IN(cfg_sel), .CFG_START_IN(cfg_start), .CFG_LEN_IN(cfg_len),
    .ACT_IN(act), .SLOT_SEL_OUT(sel), .MTP_SOM_OUT(som),
    .ACT_SEQ_OUT(act_seq), .ACT_BUSY_OUT(busy), .ACT_DONE_OUT(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic map_clear();
    for (int s = 0; s < 64; s++) exp_map[s] = 2'd0;
    exp_map[0] = 2'd3;
  endtask

  task automatic map_fill(input int lo, input int hi, input logic [1:0] code);
    for (int s = lo; s <= hi; s++) exp_map[s] = code;
  endtask

  // Config write with scheduling paused; the MTP restarts afterwards.
  task automatic cfg_idle(input logic s, input logic [5:0] st, input logic [5:0] ln);
    en = 1'b0; cfg_wr = 1'b1; cfg_sel = s; cfg_start = st; cfg_len = ln;
    tick();
    cfg_wr = 1'b0; en = 1'b1;
  endtask

  // One full MTP starting at slot 0; optional ACT / CFG write at a given cycle.
  task automatic run_mtp(input bit exp_act, input bit exp_done, input bit exp_busy_end,
                         input int act_at, input int wr_at);
    for (int i = 0; i < 32; i++) begin
      tick();
      act = 1'b0; cfg_wr = 1'b0;
      check("mtp_som", som, (i == 0));
      check("slot_sel", sel, {exp_map[2*i+1], exp_map[2*i]});
      check("act_seq", act_seq, (exp_act && i == 0));
      check("act_done", done, (exp_done && i == 0));
      if (i == act_at) act = 1'b1;
      if (i == wr_at) begin
        cfg_wr = 1'b1; cfg_sel = wr_sel_v; cfg_start = wr_start_v; cfg_len = wr_len_v;
      end
    end
    check("busy_end", busy, exp_busy_end);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_sel = 1'b0; act = 1'b0;
    cfg_start = 6'd0; cfg_len = 6'd0;
    wr_sel_v = 1'b0; wr_start_v = 6'd0; wr_len_v = 6'd0;
    repeat (3) tick();
    check("rst_sel", sel, 0);
    check("rst_som", som, 0);
    check("rst_actseq", act_seq, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0; en = 1'b1;

    // No allocation: MTPH + fill only, SOM every 32 cycles.
    map_clear();
    run_mtp(0, 0, 0, -1, -1);
    run_mtp(0, 0, 0, -1, -1);

    // Reset in the middle of SEND aborts with no swap.
    cfg_idle(1'b0, 6'd1, 6'd10);
    run_mtp(0, 0, 1, 5, -1);
    run_mtp(1, 0, 1, -1, -1);
    run_mtp(1, 0, 1, -1, -1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_sel", sel, 0);
    check("midrst_som", som, 0);
    check("midrst_actseq", act_seq, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    run_mtp(0, 0, 0, -1, -1);
    run_mtp(0, 0, 0, -1, -1);

    // s0 1/10, s1 rewritten to 11/20 during SEND; extra ACT ignored.
    cfg_idle(1'b0, 6'd1, 6'd10);
    cfg_idle(1'b1, 6'd11, 6'd5);
    run_mtp(0, 0, 1, 5, -1);
    run_mtp(1, 0, 1, -1, -1);
    wr_sel_v = 1'b1; wr_start_v = 6'd11; wr_len_v = 6'd20;
    run_mtp(1, 0, 1, 5, 7);
    run_mtp(1, 0, 1, -1, -1);
    run_mtp(1, 0, 1, -1, -1);
    map_clear(); map_fill(1, 10, 2'd1); map_fill(11, 30, 2'd2);
    run_mtp(0, 1, 0, -1, -1);
    run_mtp(0, 0, 0, -1, -1);

    // Overlap allocation; a write coincident with the swap copy waits.
    cfg_idle(1'b0, 6'd1, 6'd20);
    cfg_idle(1'b1, 6'd10, 6'd20);
    run_mtp(0, 0, 1, 5, -1);
    run_mtp(1, 0, 1, -1, -1);
    run_mtp(1, 0, 1, -1, -1);
    run_mtp(1, 0, 1, -1, -1);
    wr_sel_v = 1'b1; wr_start_v = 6'd60; wr_len_v = 6'd10;
    run_mtp(1, 0, 1, -1, 31);
    map_clear(); map_fill(1, 20, 2'd1); map_fill(21, 29, 2'd2);
    wr_sel_v = 1'b0; wr_start_v = 6'd0; wr_len_v = 6'd5;
    run_mtp(0, 1, 1, 5, 10);
    run_mtp(1, 0, 1, -1, -1);
    run_mtp(1, 0, 1, -1, -1);
    run_mtp(1, 0, 1, -1, -1);
    run_mtp(1, 0, 1, -1, -1);
    // Clip at 63 and start 0 treated as 1.
    map_clear(); map_fill(1, 5, 2'd1); map_fill(60, 63, 2'd2);
    run_mtp(0, 1, 0, -1, -1);

    // Enable dropped mid-MTP for 5 cycles.
    repeat (10) tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("endrop_sel", sel, 0);
      check("endrop_som", som, 0);
    end
    en = 1'b1;
    run_mtp(0, 0, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
